sm_ps2_rx: RTL and testbench

SM_PS2_RX -- requirements
Module: sm_ps2_rx

---
 rtl/sm_ps2_pkg.sv | 22 ++
 rtl/sm_ps2_filter.sv | 49 ++++
 rtl/sm_ps2_rx.sv | 187 ++++++++++++++++++
 tb/tb_sm_ps2_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sm_ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM state encoding, frame
// geometry and default filter/timeout settings.
package sm_ps2_pkg;

  localparam int DATA_BITS          = 8;
  localparam int BIT_CNT_W          = $clog2(DATA_BITS);
  localparam int DEFAULT_FILTER_LEN = 8;
  localparam int DEFAULT_TIMEOUT    = 5000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Odd parity over the data byte plus the received parity bit.
  function automatic logic parity_ok(input logic [DATA_BITS-1:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/sm_ps2_filter.sv
// Two-flop synchronizer followed by a saturating-counter glitch filter.
// The filtered line only follows the synchronized line after FILTER_LEN
// consecutive samples disagree with the current filtered value.
module sm_ps2_filter
  import sm_ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic line_raw,
  output logic line_filt
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic          meta_q;
  logic          sync_q;
  logic [CW-1:0] cnt_q;

  // Synchronizer; resets to the idle-bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= line_raw;
      sync_q <= meta_q;
    end
  end

  // Count disagreeing samples; any agreeing sample restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      line_filt <= 1'b1;
    end else if (sync_q != line_filt) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        line_filt <= sync_q;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      cnt_q <= '0;
    end
  end

endmodule

// File: rtl/sm_ps2_rx.sv
// PS/2 device-to-host receiver: filtered clock/data, frame FSM with
// parity/stop/timeout checks, and output storage.
// Handshake: a byte transfers on any cycle where out_valid & out_ready are
// both 1; out_valid never drops and out_data never changes until then.
// Build option: define SM_PS2_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO;
// otherwise a single holding register is used.
module sm_ps2_rx
  import sm_ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ps2_clk,
  input  logic                 ps2_data,
  output logic [DATA_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output state_t               dbg_state
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic clk_filt, data_filt, clk_prev_q, fall;

  sm_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .rst(rst), .line_raw(ps2_clk), .line_filt(clk_filt)
  );

  sm_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .rst(rst), .line_raw(ps2_data), .line_filt(data_filt)
  );

  // Previous filtered clock, for the falling-edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clk_prev_q <= 1'b1;
    else     clk_prev_q <= clk_filt;
  end

  assign fall = clk_prev_q & ~clk_filt;

  state_t                 state_q, state_nxt;
  logic [BIT_CNT_W-1:0]   bit_q, bit_nxt;
  logic [DATA_BITS-1:0]   shift_q, shift_nxt;
  logic                   par_q, par_nxt;
  logic [TW-1:0]          to_q, to_nxt;
  logic                   push, perr_nxt, ferr_nxt;
  logic                   full, pop, push_ok;

  assign dbg_state = state_q;

  // Frame FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      bit_q      <= bit_nxt;
      shift_q    <= shift_nxt;
      par_q      <= par_nxt;
      to_q       <= to_nxt;
      parity_err <= perr_nxt;
      frame_err  <= ferr_nxt;
      overrun    <= push & ~push_ok;
    end
  end

  // Next-state: sample on filtered falling edges, abort on inactivity.
  always_comb begin
    state_nxt = state_q;
    bit_nxt   = bit_q;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    to_nxt    = to_q;
    push      = 1'b0;
    perr_nxt  = 1'b0;
    ferr_nxt  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (fall && !data_filt) begin
          state_nxt = ST_DATA;
          bit_nxt   = '0;
        end
      end
      ST_DATA: begin
        if (fall) begin
          shift_nxt = {data_filt, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_nxt = ST_PARITY;
            bit_nxt   = '0;
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_nxt   = data_filt;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          state_nxt = ST_IDLE;
          if (!data_filt)                    ferr_nxt = 1'b1;
          else if (!parity_ok(shift_q, par_q)) perr_nxt = 1'b1;
          else                               push     = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Inactivity watchdog; a fresh edge always wins over expiry.
    if (state_q == ST_IDLE || fall) begin
      to_nxt = '0;
    end else if (to_q == TW'(TIMEOUT - 1)) begin
      to_nxt    = '0;
      state_nxt = ST_IDLE;
      bit_nxt   = '0;
      ferr_nxt  = 1'b1;
    end else begin
      to_nxt = to_q + 1'b1;
    end
  end

`ifdef SM_PS2_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_q, rd_q;
  logic                 empty;

  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop       = ~empty & out_ready;
  assign push_ok   = push & (~full | pop);
  assign out_valid = ~empty;
  assign out_data  = empty ? '0 : mem[rd_q[AW-1:0]];

  // FIFO pointers; the extra MSB distinguishes full from empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
    end
  end

  // FIFO storage array.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q[AW-1:0]] <= shift_q;
  end
`else
  assign full    = out_valid;
  assign pop     = out_valid & out_ready;
  assign push_ok = push & (~full | pop);

  // Single holding register; a pop frees it in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (push_ok) begin
      out_valid <= 1'b1;
      out_data  <= shift_q;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sm_ps2_rx.sv
// Bench for sm_ps2_rx: drives PS/2 frames, checks bytes through an expected
// queue and error pulses through pulse counters.
module tb_sm_ps2_rx;
  import sm_ps2_pkg::*;

  localparam int FLEN = 8;
  localparam int TOUT = 200;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       parity_err, frame_err, overrun;
  state_t     dbg_state;

  sm_ps2_rx #(.FILTER_LEN(FLEN), .TIMEOUT(TOUT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_perr = 0, n_ferr = 0, n_ovr = 0, n_pop = 0;
  logic   valid_at_stop = 1'b0;
  state_t prev_state = ST_IDLE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: sampled on the falling clock edge, away from DUT updates.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        n_pop++;
        if (exp_q.size() == 0) check("out_unexpected", 32'(exp_q.size()), 1);
        else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overrun)    n_ovr++;
      if (prev_state == ST_STOP && dbg_state == ST_IDLE) valid_at_stop = out_valid;
      prev_state = dbg_state;
    end else begin
      prev_state = ST_IDLE;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~(^d);
  endfunction

  // One PS/2 bit; optional short glitches in both clock phases.
  task automatic send_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_cyc(10);
    ps2_clk = 1'b0;
    if (glitch) begin
      wait_cyc(8); ps2_clk = 1'b1; wait_cyc(2); ps2_clk = 1'b0; wait_cyc(10);
    end else begin
      wait_cyc(20);
    end
    ps2_clk = 1'b1;
    if (glitch) begin
      wait_cyc(4); ps2_clk = 1'b0; wait_cyc(1); ps2_clk = 1'b1; wait_cyc(5);
    end else begin
      wait_cyc(10);
    end
  endtask

  // Start bit, nbits data bits; parity and stop only for a full byte.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int nbits, input bit glitch);
    send_bit(1'b0, glitch);
    for (int i = 0; i < nbits; i++) send_bit(d[i], glitch);
    if (nbits == 8) begin
      send_bit(p, glitch);
      send_bit(s, glitch);
    end
    ps2_data = 1'b1;
    wait_cyc(40);
  endtask

  task automatic send_good(input logic [7:0] d, input bit expect_out);
    if (expect_out) exp_q.push_back(d);
    send_frame(d, odd_par(d), 1'b1, 8, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pe0, fe0, ov0, pop0;
    logic [7:0] rb;

    wait_cyc(5);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_pulses", 32'({parity_err, frame_err, overrun}), 0);
    rst = 1'b0;
    wait_cyc(20);

    // Good frame 0x1C: valid the cycle after the stop edge, single pop.
    pop0 = n_pop;
    send_good(8'h1C, 1'b1);
    check("lat_valid", 32'(valid_at_stop), 1);
    check("t1_pops", 32'(n_pop - pop0), 1);
    check("t1_valid_gone", 32'(out_valid), 0);
    check("t1_errs", 32'(n_perr + n_ferr + n_ovr), 0);

    // Bad parity, then a good 0xF0.
    pop0 = n_pop;
    send_frame(8'h1C, 1'b1, 1'b1, 8, 1'b0);
    check("t2_perr", 32'(n_perr), 1);
    check("t2_no_out", 32'(n_pop - pop0), 0);
    send_good(8'hF0, 1'b1);
    check("t2_f0_pops", 32'(n_pop - pop0), 1);

    // Bad stop bit, then timeout mid-frame, then recovery with 0x29.
    pop0 = n_pop;
    send_frame(8'h5A, 1'b1, 1'b0, 8, 1'b0);
    check("t3_stop_ferr", 32'(n_ferr), 1);
    check("t3_stop_no_out", 32'(n_pop - pop0), 0);
    send_frame(8'h5A, 1'b0, 1'b1, 5, 1'b0);
    wait_cyc(TOUT + 10);
    check("t3_to_ferr", 32'(n_ferr), 2);
    check("t3_to_state", 32'(dbg_state), 32'(ST_IDLE));
    send_good(8'h29, 1'b1);
    check("t3_29_pops", 32'(n_pop - pop0), 1);
    check("t3_perr_same", 32'(n_perr), 1);

    // Back-pressure and overrun.
    out_ready = 1'b0;
    ov0 = n_ovr;
`ifdef SM_PS2_RX_FIFO_EN
    for (int i = 1; i <= 5; i++) send_good(8'(i), i <= 4);
    check("t4_ovr", 32'(n_ovr - ov0), 1);
    check("t4_head", 32'(out_data), 32'h01);
`else
    send_good(8'h11, 1'b1);
    check("t4_hold_data", 32'(out_data), 32'h11);
    send_good(8'h22, 1'b0);
    check("t4_ovr", 32'(n_ovr - ov0), 1);
    check("t4_held_data", 32'(out_data), 32'h11);
`endif
    check("t4_held_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    wait_cyc(10);
    check("t4_drained", 32'(exp_q.size()), 0);
    check("t4_valid_low", 32'(out_valid), 0);

    // Reset in the middle of a frame.
    pe0 = n_perr; fe0 = n_ferr; ov0 = n_ovr;
    send_frame(8'h3C, 1'b0, 1'b1, 4, 1'b0);
    rst = 1'b1;
    wait_cyc(3);
    check("t5_state", 32'(dbg_state), 32'(ST_IDLE));
    check("t5_valid", 32'(out_valid), 0);
    check("t5_data", 32'(out_data), 0);
    rst = 1'b0;
    wait_cyc(TOUT + 50);
    check("t5_no_err", 32'((n_perr - pe0) + (n_ferr - fe0) + (n_ovr - ov0)), 0);
    pop0 = n_pop;
    send_good(8'h3C, 1'b1);
    check("t5_3c_pops", 32'(n_pop - pop0), 1);

    // Glitches on ps2_clk shorter than the filter.
    pop0 = n_pop; fe0 = n_ferr;
    exp_q.push_back(8'h76);
    send_frame(8'h76, 1'b0, 1'b1, 8, 1'b1);
    check("t6_pops", 32'(n_pop - pop0), 1);
    check("t6_no_ferr", 32'(n_ferr - fe0), 0);

    // A few random good bytes.
    pop0 = n_pop;
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send_good(rb, 1'b1);
    end
    check("rand_pops", 32'(n_pop - pop0), 4);

    check("final_q_empty", 32'(exp_q.size()), 0);
    check("final_perr", 32'(n_perr), 1);
    check("final_ferr", 32'(n_ferr), 2);
    check("final_ovr", 32'(n_ovr), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
